axi_lite_req_arbiter: RTL and testbench
=======================================

Name: axi_lite_req_arbiter

Overview:
- Shares one AXI-lite master port between N_REQ simple command requesters, for example the VGA config writer and the debug/readback path.
- Arbitrates round-robin and runs exactly one single-beat read or write transaction at a time.
- Returns the read data and response to the requester that issued the command.
- Sits between the requester logic and the AXI-lite interconnect that reaches the controller registers and frame memory.

Parameters:
N_REQ, 2, number of requesters (2..8)
AXI_ADDR_WIDTH, 32, AXI address width
AXI_DATA_WIDTH, 64, AXI data width; STRB_WIDTH = AXI_DATA_WIDTH/8
TIMEOUT_CYCLES, 256, response watchdog limit (used only with the optional feature)

Ports:
a_clk  in  1  clock
a_resetn  in  1  async active-low reset
req_valid  in  N_REQ  command valid, one bit per requester
req_ready  out  N_REQ  command accepted
req_write  in  N_REQ  1=write, 0=read
req_addr  in  N_REQ*AXI_ADDR_WIDTH  packed addresses; requester i occupies slice i
req_wdata  in  N_REQ*AXI_DATA_WIDTH  packed write data
req_wstrb  in  N_REQ*STRB_WIDTH  packed write strobes
rsp_valid  out  N_REQ  one-cycle response pulse to the owning requester
rsp_rdata  out  AXI_DATA_WIDTH  read data, valid with rsp_valid (0 for writes)
rsp_resp  out  2  AXI response code, valid with rsp_valid
ar_valid, ar_ready, ar_addr, ar_prot  out/in/out/out  1/1/AW/3  read address channel
r_valid, r_ready, r_data, r_resp  in/out/in/in  1/1/DW/2  read data channel
aw_valid, aw_ready, aw_addr, aw_prot  out/in/out/out  1/1/AW/3  write address channel
w_valid, w_ready, w_data, w_strb  out/in/out/out  1/1/DW/SW  write data channel
b_valid, b_ready, b_resp  in/out/in  1/1/2  write response channel
timeout_err  out  1  sticky watchdog flag (tied to 0 without the optional feature)

Behaviour:
- Clock and reset: single clock a_clk; a_resetn asynchronous, active-low.
- Reset values:
  - All outputs 0, including req_ready, rsp_valid, every AXI valid/ready, addr, data, strb and timeout_err.
  - FSM goes to IDLE; round-robin pointer rr_ptr = 0.
- ar_prot and aw_prot are constant 3'b000.
- FSM states: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, RESP, plus FLUSH with the optional feature.
- IDLE:
  - Grant g is the first asserted req_valid bit searching upward from rr_ptr, wrapping modulo N_REQ.
  - req_ready[g] = 1 combinationally; all other req_ready bits are 0.
  - req_ready is 0 in every state other than IDLE.
  - On req_valid[g] & req_ready[g]: latch write, addr, wdata, wstrb and owner=g; set rr_ptr = (g+1) mod N_REQ.
  - Next state is WR_ADDR for a write, RD_ADDR for a read.
- WR_ADDR:
  - aw_valid and w_valid are asserted together.
  - Each valid deasserts independently the cycle after its own handshake; the two may complete in either order.
  - When both handshakes have completed, go to WR_RESP.
  - aw_addr, w_data and w_strb stay stable while their valid is high.
- WR_RESP: b_ready = 1; on b_valid, capture b_resp and go to RESP.
- RD_ADDR: ar_valid = 1 until ar_ready; then go to RD_DATA.
- RD_DATA: r_ready = 1; on r_valid, capture r_data and r_resp and go to RESP.
- RESP:
  - rsp_valid[owner] = 1 for exactly one cycle, then IDLE.
  - No backpressure on the response.
  - rsp_rdata and rsp_resp hold the captured values until the next RESP.
- Minimum latency, slave always ready:
  - Write: accept in cycle 0, AW/W in cycle 1, B in cycle 2, rsp_valid in cycle 3.
  - Read: accept in cycle 0, AR in cycle 1, R in cycle 2, rsp_valid in cycle 3.
  - Back-to-back commands: a new accept happens in the cycle after RESP.
- Boundary conditions:
  - Requests arriving during a transaction wait; none are dropped.
  - Deasserting req_valid before acceptance is allowed.
  - If only one requester is active it is granted every turn.
  - rr_ptr advances only on an accept.
  - Reset mid-transaction forces all AXI valids and readies low immediately, because reset is asynchronous.

Optional Feature:
AXI_ARB_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WR_RESP or RD_DATA and increments each cycle spent waiting there.
  - When it reaches TIMEOUT_CYCLES, the block pulses rsp_valid[owner] with rsp_resp = 2'b10 (SLVERR) and rsp_rdata = 0, sets timeout_err (sticky until reset) and enters FLUSH.
  - FLUSH keeps b_ready or r_ready high until the late beat arrives, discards that beat, then returns to IDLE.
  - No new grant is issued while in FLUSH.
- Not defined: no counter and no FLUSH state; timeout_err is tied to 0; the block waits indefinitely.

Test Plan:
- Requester 0 writes addr 0x10, data 0x1122334455667788, strb 0xFF; slave always ready, b_resp=00 -> AW and W handshake in cycle 1, rsp_valid[0] in cycle 3 with rsp_resp=00.
- Requester 1 reads 0x20; ar_ready delayed 3 cycles, r_data=0xDEADBEEF, r_resp=00 -> ar_addr stable through the wait, rsp_valid[1] with rsp_rdata=0xDEADBEEF.
- Write with w_ready before aw_ready (W at cycle 1, AW at cycle 4) -> w_valid drops after cycle 1, aw_valid held until cycle 4, exactly one B accepted.
- Both requesters assert req_valid continuously with reads -> grants alternate 0,1,0,1; each rsp_valid goes only to the owner.
- a_resetn pulsed low during RD_DATA -> all outputs 0 immediately, FSM in IDLE, next grant goes to requester 0.
- With AXI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, b_valid withheld for 30 cycles -> rsp_resp=10 at wait cycle 16, timeout_err=1, late B consumed, then IDLE.

Source files
------------

// File: rtl/axi_lite_req_arbiter.sv
// Round-robin arbiter sharing one AXI-lite master port between N_REQ single-beat command requesters.
// Optional response watchdog with FLUSH recovery is enabled by defining AXI_ARB_TIMEOUT_EN.
module axi_lite_req_arbiter #(
  parameter int unsigned N_REQ          = 2,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  localparam int unsigned STRB_WIDTH    = AXI_DATA_WIDTH / 8
) (
  input  logic                                a_clk,
  input  logic                                a_resetn,
  input  logic [N_REQ-1:0]                    req_valid,
  output logic [N_REQ-1:0]                    req_ready,
  input  logic [N_REQ-1:0]                    req_write,
  input  logic [N_REQ*AXI_ADDR_WIDTH-1:0]     req_addr,
  input  logic [N_REQ*AXI_DATA_WIDTH-1:0]     req_wdata,
  input  logic [N_REQ*STRB_WIDTH-1:0]         req_wstrb,
  output logic [N_REQ-1:0]                    rsp_valid,
  output logic [AXI_DATA_WIDTH-1:0]           rsp_rdata,
  output logic [1:0]                          rsp_resp,
  output logic                                ar_valid,
  input  logic                                ar_ready,
  output logic [AXI_ADDR_WIDTH-1:0]           ar_addr,
  output logic [2:0]                          ar_prot,
  input  logic                                r_valid,
  output logic                                r_ready,
  input  logic [AXI_DATA_WIDTH-1:0]           r_data,
  input  logic [1:0]                          r_resp,
  output logic                                aw_valid,
  input  logic                                aw_ready,
  output logic [AXI_ADDR_WIDTH-1:0]           aw_addr,
  output logic [2:0]                          aw_prot,
  output logic                                w_valid,
  input  logic                                w_ready,
  output logic [AXI_DATA_WIDTH-1:0]           w_data,
  output logic [STRB_WIDTH-1:0]               w_strb,
  input  logic                                b_valid,
  output logic                                b_ready,
  input  logic [1:0]                          b_resp,
  output logic                                timeout_err
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RESP
`ifdef AXI_ARB_TIMEOUT_EN
    , FLUSH
`endif
  } state_t;

  state_t                    state, state_n;
  logic [PTR_W-1:0]          rr_ptr, owner, grant, idx;
  logic                      found, accept;
  logic                      cmd_write, aw_done, w_done;
  logic [AXI_ADDR_WIDTH-1:0] cmd_addr;
  logic [AXI_DATA_WIDTH-1:0] cmd_wdata;
  logic [STRB_WIDTH-1:0]     cmd_wstrb;
  logic                      waiting, beat, tmo_fire;
  logic                      flush_pend;

  assign ar_prot = 3'b000;
  assign aw_prot = 3'b000;
  assign ar_addr = cmd_addr;
  assign aw_addr = cmd_addr;
  assign w_data  = cmd_wdata;
  assign w_strb  = cmd_wstrb;

  assign accept  = (state == IDLE) && found;
  assign waiting = (state == WR_RESP) || (state == RD_DATA);
  assign beat    = ((state == WR_RESP) && b_valid) || ((state == RD_DATA) && r_valid);

  // First asserted request at or above rr_ptr, wrapping.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = PTR_W'((32'(rr_ptr) + k) % N_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) state <= IDLE;
    else           state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (found) state_n = req_write[grant] ? WR_ADDR : RD_ADDR;
      WR_ADDR: if ((aw_done || aw_ready) && (w_done || w_ready)) state_n = WR_RESP;
      WR_RESP: if (b_valid || tmo_fire) state_n = RESP;
      RD_ADDR: if (ar_ready) state_n = RD_DATA;
      RD_DATA: if (r_valid || tmo_fire) state_n = RESP;
`ifdef AXI_ARB_TIMEOUT_EN
      RESP:    state_n = flush_pend ? FLUSH : IDLE;
      FLUSH:   if (cmd_write ? b_valid : r_valid) state_n = IDLE;
`else
      RESP:    state_n = IDLE;
`endif
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    aw_valid  = 1'b0;
    w_valid   = 1'b0;
    b_ready   = 1'b0;
    ar_valid  = 1'b0;
    r_ready   = 1'b0;
    case (state)
      IDLE:    if (found) req_ready[grant] = 1'b1;
      WR_ADDR: begin
        aw_valid = !aw_done;
        w_valid  = !w_done;
      end
      WR_RESP: b_ready = 1'b1;
      RD_ADDR: ar_valid = 1'b1;
      RD_DATA: r_ready = 1'b1;
      RESP:    rsp_valid[owner] = 1'b1;
`ifdef AXI_ARB_TIMEOUT_EN
      FLUSH: begin
        b_ready = cmd_write;
        r_ready = !cmd_write;
      end
`endif
      default: ;
    endcase
  end

  // Command latch, per-channel handshake tracking and response capture.
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      rr_ptr    <= '0;
      owner     <= '0;
      cmd_write <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_wstrb <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
    end else begin
      if (accept) begin
        cmd_write <= req_write[grant];
        cmd_addr  <= req_addr[grant*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        cmd_wdata <= req_wdata[grant*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
        cmd_wstrb <= req_wstrb[grant*STRB_WIDTH +: STRB_WIDTH];
        owner     <= grant;
        rr_ptr    <= (grant == PTR_W'(N_REQ - 1)) ? '0 : grant + PTR_W'(1);
        aw_done   <= 1'b0;
        w_done    <= 1'b0;
      end
      if (state == WR_ADDR) begin
        if (aw_valid && aw_ready) aw_done <= 1'b1;
        if (w_valid && w_ready)   w_done  <= 1'b1;
      end
      if ((state == WR_RESP) && b_valid) begin
        rsp_resp  <= b_resp;
        rsp_rdata <= '0;
      end
      if ((state == RD_DATA) && r_valid) begin
        rsp_resp  <= r_resp;
        rsp_rdata <= r_data;
      end
      if (tmo_fire) begin
        rsp_resp  <= 2'b10;
        rsp_rdata <= '0;
      end
    end
  end

`ifdef AXI_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;

  assign tmo_fire = waiting && !beat && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Wait counter restarts whenever the FSM is outside a response-wait state.
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      tmo_cnt     <= '0;
      flush_pend  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (waiting && !tmo_fire) tmo_cnt <= tmo_cnt + CNT_W'(1);
      else                      tmo_cnt <= '0;
      if (tmo_fire) begin
        flush_pend  <= 1'b1;
        timeout_err <= 1'b1;
      end else if (state == FLUSH) begin
        flush_pend  <= 1'b0;
      end
    end
  end
`else
  logic unused_tmo;
  assign tmo_fire    = 1'b0;
  assign flush_pend  = 1'b0;
  assign timeout_err = 1'b0;
  assign unused_tmo  = ^{32'(TIMEOUT_CYCLES), waiting, beat, flush_pend};
`endif

endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
// Directed self-checking bench for axi_lite_req_arbiter (default build, N_REQ=2).
module tb_axi_lite_req_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned SW = DW / 8;

  logic            a_clk = 1'b0;
  logic            a_resetn = 1'b0;
  logic [N-1:0]    req_valid, req_ready, req_write, rsp_valid;
  logic [AW-1:0]   addr0, addr1;
  logic [DW-1:0]   wdata0, wdata1;
  logic [SW-1:0]   strb0, strb1;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_wstrb;
  logic [DW-1:0]   rsp_rdata, r_data, w_data;
  logic [1:0]      rsp_resp, r_resp, b_resp;
  logic            ar_valid, ar_ready, r_valid, r_ready;
  logic            aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic [AW-1:0]   ar_addr, aw_addr;
  logic [2:0]      ar_prot, aw_prot;
  logic [SW-1:0]   w_strb;
  logic            timeout_err;

  assign req_addr  = {addr1, addr0};
  assign req_wdata = {wdata1, wdata0};
  assign req_wstrb = {strb1, strb0};

  axi_lite_req_arbiter #(.N_REQ(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
    .a_clk(a_clk), .a_resetn(a_resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_prot(ar_prot),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_prot(aw_prot),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
    .timeout_err(timeout_err)
  );

  always #5 a_clk = ~a_clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step;
    @(posedge a_clk);
    #1;
  endtask

  // One read with an always-ready slave: accept, AR, R, RESP.
  task automatic do_read(input string tag, input logic [1:0] oh, input logic [31:0] addr,
                         input logic [63:0] data);
    #1 check({tag, "_req_ready"}, 64'(req_ready), 64'(oh));
    step;
    check({tag, "_ar_valid"}, 64'(ar_valid), 64'd1);
    check({tag, "_ar_addr"}, 64'(ar_addr), 64'(addr));
    step;
    check({tag, "_r_ready"}, 64'(r_ready), 64'd1);
    step;
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(oh));
    check({tag, "_rsp_rdata"}, rsp_rdata, data);
    step;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    req_valid = '0; req_write = '0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; strb0 = '0; strb1 = '0;
    ar_ready = 0; r_valid = 0; r_data = '0; r_resp = 0;
    aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = 0;

    #12;
    check("rst_valids", 64'({aw_valid, w_valid, b_ready, ar_valid, r_ready}), 64'd0);
    check("rst_req_rsp", 64'({req_ready, rsp_valid, rsp_resp, timeout_err}), 64'd0);
    check("rst_addr", 64'({aw_addr, ar_addr}), 64'd0);
    check("rst_wdata", w_data, 64'd0);
    check("rst_strb_prot", 64'({w_strb, ar_prot, aw_prot}), 64'd0);
    check("rst_rdata", rsp_rdata, 64'd0);

    @(posedge a_clk); #1 a_resetn = 1'b1;

    // Write from requester 0, slave always ready.
    req_valid = 2'b01; req_write = 2'b01;
    addr0 = 32'h10; wdata0 = 64'h1122334455667788; strb0 = 8'hFF;
    aw_ready = 1; w_ready = 1; b_valid = 1; b_resp = 2'b00;
    #1 check("wr_req_ready", 64'(req_ready), 64'b01);
    step; req_valid = '0;
    check("wr_c1_valids", 64'({aw_valid, w_valid}), 64'b11);
    check("wr_c1_aw_addr", 64'(aw_addr), 64'h10);
    check("wr_c1_w_data", w_data, 64'h1122334455667788);
    check("wr_c1_w_strb", 64'(w_strb), 64'hFF);
    check("wr_c1_req_ready", 64'(req_ready), 64'd0);
    step;
    check("wr_c2_valids", 64'({aw_valid, w_valid}), 64'b00);
    check("wr_c2_b_ready", 64'(b_ready), 64'd1);
    step; b_valid = 0;
    check("wr_c3_rsp_valid", 64'(rsp_valid), 64'b01);
    check("wr_c3_rsp_resp", 64'(rsp_resp), 64'd0);
    check("wr_c3_rsp_rdata", rsp_rdata, 64'd0);
    step;
    check("wr_c4_rsp_valid", 64'(rsp_valid), 64'd0);
    aw_ready = 0; w_ready = 0;

    // Read from requester 1 with ar_ready held off for three cycles.
    req_valid = 2'b10; req_write = 2'b00; addr1 = 32'h20;
    #1 check("rd_req_ready", 64'(req_ready), 64'b10);
    step; req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      check("rd_ar_wait_valid", 64'(ar_valid), 64'd1);
      check("rd_ar_wait_addr", 64'(ar_addr), 64'h20);
      step;
    end
    ar_ready = 1;
    #1 check("rd_ar_hs_valid", 64'(ar_valid), 64'd1);
    step; ar_ready = 0;
    check("rd_ar_dropped", 64'(ar_valid), 64'd0);
    check("rd_r_ready", 64'(r_ready), 64'd1);
    r_valid = 1; r_data = 64'hDEADBEEF; r_resp = 2'b00;
    step; r_valid = 0;
    check("rd_rsp_valid", 64'(rsp_valid), 64'b10);
    check("rd_rsp_rdata", rsp_rdata, 64'hDEADBEEF);
    check("rd_rsp_resp", 64'(rsp_resp), 64'd0);
    step;
    check("rd_rsp_pulse", 64'(rsp_valid), 64'd0);
    check("rd_rdata_hold", rsp_rdata, 64'hDEADBEEF);

    // Write with W accepted in cycle 1 and AW only in cycle 4.
    req_valid = 2'b01; req_write = 2'b01; addr0 = 32'h30; w_ready = 1;
    #1 check("wo_req_ready", 64'(req_ready), 64'b01);
    step; req_valid = '0;
    check("wo_c1_valids", 64'({aw_valid, w_valid}), 64'b11);
    step; w_ready = 0;
    check("wo_c2_valids", 64'({aw_valid, w_valid}), 64'b10);
    step;
    check("wo_c3_valids", 64'({aw_valid, w_valid}), 64'b10);
    step; aw_ready = 1;
    #1 check("wo_c4_valids", 64'({aw_valid, w_valid}), 64'b10);
    check("wo_c4_aw_addr", 64'(aw_addr), 64'h30);
    step; aw_ready = 0;
    check("wo_c5_valids", 64'({aw_valid, w_valid}), 64'b00);
    check("wo_c5_b_ready", 64'(b_ready), 64'd1);
    b_valid = 1; b_resp = 2'b01;
    step; b_valid = 0;
    check("wo_rsp_valid", 64'(rsp_valid), 64'b01);
    check("wo_rsp_resp", 64'(rsp_resp), 64'd1);
    check("wo_single_b", 64'(b_ready), 64'd0);
    step;

    // Reset pulsed while waiting in RD_DATA; rr_ptr is 1 here so requester 1 wins.
    req_valid = 2'b11; req_write = 2'b00; addr0 = 32'h100; addr1 = 32'h200; ar_ready = 1;
    #1 check("rst_mid_grant", 64'(req_ready), 64'b10);
    step; req_valid = '0;
    check("rst_mid_ar_addr", 64'(ar_addr), 64'h200);
    step;
    check("rst_mid_r_ready", 64'(r_ready), 64'd1);
    #2 a_resetn = 1'b0;
    #1;
    check("rst_mid_valids", 64'({aw_valid, w_valid, b_ready, ar_valid, r_ready}), 64'd0);
    check("rst_mid_outs", 64'({req_ready, rsp_valid, rsp_resp}), 64'd0);
    check("rst_mid_ar_addr0", 64'(ar_addr), 64'd0);
    @(posedge a_clk); #1 a_resetn = 1'b1;

    // Both requesters read continuously: grants alternate starting from 0.
    req_valid = 2'b11; r_valid = 1; r_data = 64'h0123456789ABCDEF; r_resp = 2'b00;
    for (int t = 0; t < 4; t++) begin
      if (t % 2 == 0) do_read("alt0", 2'b01, 32'h100, 64'h0123456789ABCDEF);
      else            do_read("alt1", 2'b10, 32'h200, 64'h0123456789ABCDEF);
    end

    // Only requester 1 active: granted every turn.
    req_valid = 2'b10; r_data = 64'hCAFE;
    do_read("solo_a", 2'b10, 32'h200, 64'hCAFE);
    do_read("solo_b", 2'b10, 32'h200, 64'hCAFE);

    // Requester 1 withdraws before acceptance; requester 0 then wins.
    req_valid = 2'b00; r_valid = 0;
    #1 check("idle_no_req", 64'(req_ready), 64'd0);
    r_valid = 1; r_data = 64'h77;
    req_valid = 2'b01;
    do_read("after_drop", 2'b01, 32'h100, 64'h77);
    req_valid = '0; r_valid = 0; ar_ready = 0;

    check("timeout_err_off", 64'(timeout_err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
